// File: rtl/pcs_tx_pkg.sv
// pcs_tx_pkg: shared encodings, block type and bit-order helper for the 10GBASE-R TX back end
package pcs_tx_pkg;

    localparam logic [1:0] HDR_DATA = 2'b10;
    localparam logic [1:0] HDR_CTRL = 2'b01;

    typedef struct packed {
        logic [1:0]  head;
        logic [63:0] data;
    } blk_t;

    localparam blk_t IDLE_BLOCK = '{head: HDR_CTRL, data: 64'h0000_0000_0000_001E};

    localparam int SCR_TAP_A = 58;
    localparam int SCR_TAP_B = 39;

    // Reverses bit order inside every n-bit lane; n=64 reverses the whole word.
    function automatic logic [63:0] bit_rev(input logic [63:0] w, input int n);
        logic [63:0] r;
        for (int i = 0; i < 64; i++)
            r[i] = w[6'((i / n) * n + n - 1 - i % n)];
        return r;
    endfunction

endpackage

// File: rtl/scrambler_58.sv
// scrambler_58: 64-bit parallel self-synchronous x^58+x^39+1 scrambler, LSB first, with enable and bypass
module scrambler_58
    import pcs_tx_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        en_i,
    input  logic        bypass_i,
    input  logic [63:0] data_i,
    output logic [63:0] data_o
);

    logic [57:0]  state_q, state_d;
    logic [121:0] ext;

    // ext holds the scrambled bit history oldest-first: state, then this word's output bits
    always_comb begin
        ext = {64'b0, state_q};
        for (int i = 0; i < 64; i++)
            ext[58 + i] = data_i[i] ^ ext[58 + i - SCR_TAP_B] ^ ext[58 + i - SCR_TAP_A];
        data_o  = bypass_i ? data_i : ext[121:58];
        state_d = (en_i && !bypass_i) ? ext[121:64] : state_q;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) state_q <= '1;
        else          state_q <= state_d;
    end

endmodule

// File: rtl/pcs_tx_gearbox.sv
// pcs_tx_gearbox: 10GBASE-R TX block FIFO, idle insertion, scrambler and GT external-sequence gearbox driver
module pcs_tx_gearbox
    import pcs_tx_pkg::*;
#(
    parameter int GT_W       = 32,
    parameter int FIFO_DEPTH = 4,
    parameter bit BIT_REV    = 1'b1
) (
    input  logic            clk_i,
    input  logic            rst_n_i,
    input  logic [63:0]     blk_data_i,
    input  logic [1:0]      blk_head_i,
    input  logic            blk_valid_i,
    output logic            blk_ready_o,
    input  logic            cfg_scr_bypass_i,
    output logic [GT_W-1:0] gt_data_o,
    output logic [5:0]      gt_head_o,
    output logic [6:0]      gt_sequence_o,
    output logic            underflow_o,
    output logic [15:0]     underflow_cnt_o
);

    localparam int         AW      = $clog2(FIFO_DEPTH);
    localparam logic [6:0] PH_LAST = (GT_W == 64) ? 7'd32 : 7'd65;

    blk_t            mem_q [FIFO_DEPTH];
    blk_t            mem_d [FIFO_DEPTH];
    logic [AW:0]     wr_q, wr_d, rd_q, rd_d, fill;
    logic            ready_q, ready_d, armed_q, armed_d, under_q, under_d;
    logic [15:0]     cnt_q, cnt_d;
    logic [6:0]      ph_q, ph_d, ph1_q, ph1_d, seq_q, seq_d, seq_w;
    blk_t            s1_q, s1_d, pop;
    logic [GT_W-1:0] data_q, data_d, word;
    logic [1:0]      head_q, head_d;
    logic            slot, load, empty, wr;
    logic [63:0]     scr_data;

    // ph1_q is the phase of the block held in s1_q; it steers which word leaves next
    if (GT_W == 64) begin : g_w64
        assign slot  = ph_q < 7'd32;
        assign load  = ph1_q < 7'd32;
        assign word  = s1_q.data;
        assign seq_w = ph1_q;
    end else begin : g_w32
        assign slot  = !ph_q[0] && ph_q < 7'd64;
        assign load  = ph1_q < 7'd64;
        assign word  = ph1_q[0] ? s1_q.data[63:32] : s1_q.data[31:0];
        assign seq_w = ph1_q >> 1;
    end

    always_comb begin
        fill  = wr_q - rd_q;
        empty = fill == '0;
        wr    = blk_valid_i && ready_q;
        pop   = empty ? IDLE_BLOCK : mem_q[rd_q[AW-1:0]];
    end

    scrambler_58 u_scr (
        .clk_i    (clk_i),
        .rst_n_i  (rst_n_i),
        .en_i     (slot),
        .bypass_i (cfg_scr_bypass_i),
        .data_i   (pop.data),
        .data_o   (scr_data)
    );

    always_comb begin
        mem_d = mem_q;
        if (wr) mem_d[wr_q[AW-1:0]] = '{head: blk_head_i, data: blk_data_i};
        wr_d    = wr_q + (AW+1)'(wr);
        rd_d    = rd_q + (AW+1)'(slot && !empty);
        ready_d = (wr_d - rd_d) != (AW+1)'(FIFO_DEPTH);
        armed_d = armed_q || wr;
        under_d = slot && empty && armed_q;
        cnt_d   = (under_d && cnt_q != 16'hFFFF) ? cnt_q + 16'd1 : cnt_q;
        ph_d    = (ph_q == PH_LAST) ? '0 : ph_q + 7'd1;
        ph1_d   = ph_q;
        s1_d    = s1_q;
        if (slot) begin
            s1_d.head = BIT_REV ? {pop.head[0], pop.head[1]} : pop.head;
            s1_d.data = BIT_REV ? bit_rev(scr_data, GT_W) : scr_data;
        end
        data_d  = load ? word : data_q;
        head_d  = load ? s1_q.head : head_q;
        seq_d   = seq_w;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            mem_q   <= '{default: '0};
            wr_q    <= '0;
            rd_q    <= '0;
            ready_q <= 1'b0;
            armed_q <= 1'b0;
            under_q <= 1'b0;
            cnt_q   <= '0;
            ph_q    <= '0;
            ph1_q   <= '0;
            seq_q   <= '0;
            s1_q    <= '0;
            data_q  <= '0;
            head_q  <= '0;
        end else begin
            mem_q   <= mem_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            ready_q <= ready_d;
            armed_q <= armed_d;
            under_q <= under_d;
            cnt_q   <= cnt_d;
            ph_q    <= ph_d;
            ph1_q   <= ph1_d;
            seq_q   <= seq_d;
            s1_q    <= s1_d;
            data_q  <= data_d;
            head_q  <= head_d;
        end
    end

    assign blk_ready_o     = ready_q;
    assign gt_data_o       = data_q;
    assign gt_head_o       = {4'b0, head_q};
    assign gt_sequence_o   = seq_q;
    assign underflow_o     = under_q;
    assign underflow_cnt_o = cnt_q;

endmodule

// File: doc/pcs_tx_gearbox.md
# pcs_tx_gearbox

Parametrised 10GBASE-R PCS transmit back end: accepts already-encoded 66-bit blocks over a valid/ready handshake, buffers them in a small FIFO, scrambles the 64-bit payload (x^58+x^39+1, bypassable), and drives a GT transmitter running in external-sequence-counter gearbox mode at a 32- or 64-bit fabric width. It sits between the 64b/66b encoder and the GT. It adds two things the TX path previously lacked: idle-block insertion on upstream starvation, and underflow accounting.

## Interface
- GT_W, 32, GT data width; legal values 32 or 64.
- FIFO_DEPTH, 4, block FIFO depth in 66b blocks; power of two, ≥2.
- BIT_REV, 1, when 1 each GT word and the 2-bit header are bit-reversed at the output.
- clk_i  in  1  single clock, shared by all logic.
- rst_n_i  in  1  synchronous, active-low reset.
- blk_data_i  in  64  encoded block payload; byte 0 in [7:0].
- blk_head_i  in  2  sync header; [0] is transmitted first; data=2'b10, control=2'b01.
- blk_valid_i  in  1  block present.
- blk_ready_o  out  1  FIFO not full (registered).
- cfg_scr_bypass_i  in  1  1 = payload sent unscrambled and scrambler state frozen; sampled per block.
- gt_data_o  out  GT_W  GT TX data.
- gt_head_o  out  6  {4'b0, header}.
- gt_sequence_o  out  7  GT external sequence counter value.
- underflow_o  out  1  one-cycle pulse per inserted idle block, counted as defined below.
- underflow_cnt_o  out  16  saturating underflow count.

## Operation
- Phase counter ph: GT_W=64 counts 0..32 and wraps; GT_W=32 counts 0..65 and wraps.
- Slot rules:
  - GT_W=64: a block slot occurs when ph<32.
  - GT_W=32: a block slot occurs when ph is even and <64. The low word is sent on the even ph, the high word on ph+1.
  - The remaining ph values are pause cycles: nothing is consumed, and outputs hold their previous values.
- Sequence output: gt_sequence_o = ph for GT_W=64, and ph>>1 for GT_W=32, delayed to align with the data (see Timing).
- At each slot:
  - FIFO non-empty: pop one block.
  - FIFO empty: substitute the idle block (head 2'b01, payload 64'h0000_0000_0000_001E).
- Underflow accounting:
  - An "armed" flag sets on the first accepted input block after reset.
  - Only idle substitutions while armed pulse underflow_o and increment underflow_cnt_o.
  - underflow_cnt_o saturates at 16'hFFFF.
- Scrambler:
  - Self-synchronous, LSB first, 58-bit state, reset value all ones.
  - Scrambles the payload only; the header always passes through unchanged.
  - State advances once per slot, including inserted idle blocks, unless bypass is set.
- FIFO:
  - Write when blk_valid_i && blk_ready_o.
  - blk_ready_o = !full, registered, so a pop in the same cycle does not allow a write to a full FIFO.
- Header: presented on every cycle of its block (both words for GT_W=32).

## Timing
- Reset values: gt_data_o=0, gt_head_o=0, gt_sequence_o=0, underflow_o=0, underflow_cnt_o=0, blk_ready_o=0.
- Release: blk_ready_o=1 on the first cycle after rst_n_i goes high, and ph=0.
- Latency from slot (pop) cycle to first GT word on outputs: 2 cycles (scramble register, output register). gt_sequence_o is pipelined by the same 2 cycles.
- Minimum input-to-output latency with an empty FIFO: write in cycle N, earliest pop N+1, output N+3.
- Reset asserted mid-block:
  - All state clears, including FIFO contents, ph, armed, the counter, and the scrambler.
  - A partially sent GT_W=32 block is abandoned.
- Changing cfg_scr_bypass_i takes effect at the next slot and never splits a block.

## Structure
- Package pcs_tx_pkg:
  - Header encodings HDR_DATA and HDR_CTRL.
  - IDLE_BLOCK constant.
  - Scrambler tap constants (58, 39).
  - Function for bit reversal of an N-bit word.
- Sub-module scrambler_58 (64-bit parallel, enable + bypass).
- FIFO and phase logic stay inline in pcs_tx_gearbox.
- GT_W selects behaviour through generate branches.

## Test plan
- GT_W=64, continuous valid, bypass=1, payload = incrementing 64'h1,2,3…:
  - gt_data_o shows the blocks in order.
  - Output holds on gt_sequence_o=32.
  - blk_ready_o drops when the FIFO fills during pause cycles.
  - No underflow.
- GT_W=32, single block 64'hAABBCCDD_11223344 with head 2'b10, BIT_REV=0, bypass=1:
  - Low word 32'h11223344 appears first, then 32'hAABBCCDD.
  - gt_head_o=6'h02 on both cycles.
  - gt_sequence_o steps 0,0,1,1…, then holds at 32 for two cycles.
- Scrambler enabled, all-zero payload data blocks from reset: output matches the golden model of x^58+x^39+1 with all-ones seed; headers are unscrambled.
- Starvation:
  - Before any input: idle blocks only, underflow_cnt_o stays 0.
  - After one block then a 3-slot gap: 3 underflow_o pulses, count=3, idle payload scrambled.
- Force count to 16'hFFFE, starve 5 slots: count stops at 16'hFFFF.
- Assert rst_n_i low for one cycle during the high-word cycle (GT_W=32): all outputs return to reset values, and the next block starts at ph=0 with a reseeded scrambler.
